// File: rtl/mem_responder_pkg.sv
// Shared types for the memory responder: FSM states, transaction owner, word geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} mem_state_t;

  typedef enum logic {OWN_I, OWN_D} mem_owner_t;

  localparam int WORD_BYTES = 4;
  // Byte-offset bits dropped from a byte address to form a word index.
  localparam int WORD_LSB = $clog2(WORD_BYTES);

endpackage

// File: rtl/mem_responder_if.sv
// Instruction-fetch and data-access ports between the core and the memory responder.
// Latency: n/a (wires only).
// Backpressure: initiator holds req until its one-cycle ready pulse.
interface mem_responder_if;

  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ready;
  logic [31:0] i_rdata;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
    input  i_ready, i_rdata, d_ready, d_rdata
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
    output i_ready, i_rdata, d_ready, d_rdata
  );

endinterface

// File: rtl/mem_responder_sp_ram.sv
// Single-port word store: synchronous write, registered read.
// Latency: read data appears one clock after an enabled read.
// Backpressure: none; accepts one access per clock when en is high.
module sp_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  // Contents are deliberately left unreset; benches preload this array by name.
  logic [31:0] mem [DEPTH_WORDS];

  // Write on enabled stores, otherwise register the addressed word.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: arbitrates fetch/data ports (data first) onto one word store, one transaction at a time.
// Latency: request first high in IDLE at cycle 0 -> ready pulse in cycle LATENCY+1; one txn per LATENCY+2 cycles.
// Backpressure: a request is held by its initiator until the ready pulse; the losing port simply waits.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic CLK,
  input  logic reset_n,
  mem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  mem_state_t    state, state_n;
  mem_owner_t    own;
  logic [CW-1:0] cnt;

  // Request payload captured at accept; later input changes are ignored.
  logic          lat_we;
  logic [AW-1:0] lat_idx;
  logic [31:0]   lat_wdata;

  logic          i_ready_q, d_ready_q;
  logic [31:0]   i_rdata_q, d_rdata_q;

  logic          accept_i, accept_d, finish;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_q;
  logic [AW-1:0] i_idx, d_idx;

  // Upper address bits fall off here, so out-of-range addresses wrap.
  assign i_idx = bus.i_addr[AW+WORD_LSB-1:WORD_LSB];
  assign d_idx = bus.d_addr[AW+WORD_LSB-1:WORD_LSB];

  assign bus.i_ready = i_ready_q;
  assign bus.d_ready = d_ready_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;

  sp_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk  (CLK),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(lat_wdata),
    .rdata(ram_q)
  );

  // Next state, arbitration and RAM control. Loads are read from the RAM on
  // the accept edge and on every BUSY edge, so the registered RAM output
  // already holds the word when the counter expires, even at LATENCY=1.
  // Stores touch the array only on the counter-expiry edge, so a reset
  // before then leaves memory untouched.
  always_comb begin
    state_n  = state;
    accept_i = 1'b0;
    accept_d = 1'b0;
    finish   = 1'b0;
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = lat_idx;
    case (state)
      IDLE: begin
        if (bus.d_req) begin
          accept_d = 1'b1;
          ram_addr = d_idx;
          ram_en   = ~bus.d_we;
          state_n  = BUSY;
        end else if (bus.i_req) begin
          accept_i = 1'b1;
          ram_addr = i_idx;
          ram_en   = 1'b1;
          state_n  = BUSY;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          finish  = 1'b1;
          ram_en  = 1'b1;
          ram_we  = lat_we;
          state_n = RESP;
        end else begin
          ram_en  = ~lat_we;
        end
      end
      RESP: begin
        // Always return to IDLE so a request still high this cycle is not re-accepted.
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Accept latches, latency counter, and registered ready/rdata outputs.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      own       <= OWN_I;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      i_ready_q <= finish && (own == OWN_I);
      d_ready_q <= finish && (own == OWN_D);
      if (accept_d) begin
        own       <= OWN_D;
        cnt       <= CNT_LOAD;
        lat_we    <= bus.d_we;
        lat_idx   <= d_idx;
        lat_wdata <= bus.d_wdata;
      end else if (accept_i) begin
        own       <= OWN_I;
        cnt       <= CNT_LOAD;
        lat_we    <= 1'b0;
        lat_idx   <= i_idx;
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (finish && !lat_we) begin
        if (own == OWN_D) begin
          d_rdata_q <= ram_q;
        end else begin
          i_rdata_q <= ram_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed transactions plus a timestamp-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT0  = 2;

  logic CLK = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  mem_responder_if bus0 ();
  mem_responder_if bus1 ();

  mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT0)) dut0 (
    .CLK    (CLK),
    .reset_n(reset_n),
    .bus    (bus0)
  );

  mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (
    .CLK    (CLK),
    .reset_n(reset_n),
    .bus    (bus1)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a word array plus "responder free from cycle X" and
  // "response due at cycle Y" timestamps; no state machine.
  logic [31:0] ref_mem [DEPTH];
  bit          pend = 0;
  bit          p_d, p_we;
  int          p_idx;
  logic [31:0] p_wdata;
  int          resp_at = 0;
  int          free_at = 0;
  logic        e_ir = 0, e_dr = 0;
  logic [31:0] e_ird = 0, e_drd = 0;

  always @(negedge CLK) begin : model
    if (!reset_n) begin
      pend = 0;
      free_at = cyc + 1;
      e_ir = 0; e_dr = 0; e_ird = 0; e_drd = 0;
    end else begin
      // A store lands on the edge ending the cycle before its response.
      if (pend && p_we && cyc == resp_at - 1) ref_mem[p_idx] = p_wdata;
      e_ir = 0; e_dr = 0;
      if (pend && cyc == resp_at) begin
        if (p_d) e_dr = 1; else e_ir = 1;
        if (!p_we) begin
          if (p_d) e_drd = ref_mem[p_idx]; else e_ird = ref_mem[p_idx];
        end
        pend = 0;
      end
      if (!pend && cyc >= free_at && (bus0.d_req || bus0.i_req)) begin
        pend    = 1;
        p_d     = bus0.d_req;
        p_we    = bus0.d_req ? bus0.d_we : 1'b0;
        p_idx   = int'((bus0.d_req ? bus0.d_addr : bus0.i_addr) / 4) % DEPTH;
        p_wdata = bus0.d_wdata;
        resp_at = cyc + LAT0 + 1;
        free_at = cyc + LAT0 + 2;
      end
    end
    chk("model_i_ready", {31'b0, bus0.i_ready}, {31'b0, e_ir});
    chk("model_d_ready", {31'b0, bus0.d_ready}, {31'b0, e_dr});
    chk("model_i_rdata", bus0.i_rdata, e_ird);
    chk("model_d_rdata", bus0.d_rdata, e_drd);
  end

  // One transaction on dut0; lat is the ready cycle relative to the request cycle.
  task automatic do_txn(input bit is_d, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit scramble,
                        output int lat, output logic [31:0] rd);
    int t0;
    bit seen;
    seen = 0;
    lat = -1;
    rd = '0;
    @(posedge CLK); #1;
    if (is_d) begin
      bus0.d_req = 1; bus0.d_we = we; bus0.d_addr = addr; bus0.d_wdata = wdata;
    end else begin
      bus0.i_req = 1; bus0.i_addr = addr;
    end
    t0 = cyc;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge CLK);
      if (is_d ? bus0.d_ready : bus0.i_ready) begin
        seen = 1;
        lat = cyc - t0;
        rd = is_d ? bus0.d_rdata : bus0.i_rdata;
      end
      @(posedge CLK); #1;
      if (seen) begin
        bus0.d_req = 0; bus0.i_req = 0;
      end else if (scramble) begin
        bus0.d_addr = 32'h0000_03FC; bus0.d_wdata = 32'h0BAD_0BAD; bus0.i_addr = 32'h0000_03FC;
      end
    end
    if (!seen) chk("txn_timeout", 32'd0, 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int lat;
    int t0, dcyc, icyc;
    logic [31:0] rd;
    int pulses [$];

    bus0.i_req = 0; bus0.i_addr = 0; bus0.d_req = 0; bus0.d_we = 0; bus0.d_addr = 0; bus0.d_wdata = 0;
    bus1.i_req = 0; bus1.i_addr = 0; bus1.d_req = 0; bus1.d_we = 0; bus1.d_addr = 0; bus1.d_wdata = 0;

    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = 32'hC0DE_0000 | 32'(i);
      dut0.u_ram.mem[i] = 32'hC0DE_0000 | 32'(i);
      dut1.u_ram.mem[i] = 32'hC0DE_0000 | 32'(i);
    end
    ref_mem[3] = 32'h2008_0005;
    dut0.u_ram.mem[3] = 32'h2008_0005;

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_i_ready", {31'b0, bus0.i_ready}, 32'd0);
    chk("rst_d_rdata", bus0.d_rdata, 32'd0);
    @(posedge CLK); #1;
    reset_n = 1;

    // Single fetch of word 3.
    do_txn(0, 0, 32'h0000_000C, 32'h0, 0, lat, rd);
    chk("fetch_lat", lat, 32'd3);
    chk("fetch_rdata", rd, 32'h2008_0005);

    // Simultaneous fetch and load: data first.
    @(posedge CLK); #1;
    bus0.i_req = 1; bus0.i_addr = 32'h0;
    bus0.d_req = 1; bus0.d_we = 0; bus0.d_addr = 32'h10;
    t0 = cyc; dcyc = -1; icyc = -1;
    for (int k = 0; k < 20 && icyc < 0; k++) begin
      @(negedge CLK);
      if (bus0.d_ready && dcyc < 0) begin
        dcyc = cyc - t0;
        chk("prio_d_rdata", bus0.d_rdata, 32'hC0DE_0004);
      end
      if (bus0.i_ready && icyc < 0) begin
        icyc = cyc - t0;
        chk("prio_i_rdata", bus0.i_rdata, 32'hC0DE_0000);
      end
      @(posedge CLK); #1;
      if (dcyc >= 0) bus0.d_req = 0;
      if (icyc >= 0) bus0.i_req = 0;
    end
    chk("prio_d_cycle", dcyc, 32'd3);
    chk("prio_i_cycle", icyc, 32'd7);

    // Store then load the same word through a misaligned address.
    do_txn(1, 1, 32'h0000_0044, 32'h1234_5678, 0, lat, rd);
    chk("store_lat", lat, 32'd3);
    do_txn(1, 0, 32'h0000_0047, 32'h0, 0, lat, rd);
    chk("store_load_rdata", rd, 32'h1234_5678);

    // Address beyond the array wraps.
    do_txn(1, 0, 32'h0000_1004, 32'h0, 0, lat, rd);
    chk("wrap_rdata", rd, 32'hC0DE_0001);

    // Payload changes after accept are ignored.
    do_txn(1, 1, 32'h0000_0024, 32'hCAFE_F00D, 1, lat, rd);
    do_txn(1, 0, 32'h0000_0024, 32'h0, 1, lat, rd);
    chk("scramble_store_load", rd, 32'hCAFE_F00D);
    do_txn(0, 0, 32'h0000_0020, 32'h0, 1, lat, rd);
    chk("scramble_fetch", rd, 32'hC0DE_0008);

    // Reset during BUSY of a store: outputs clear, store never lands.
    @(posedge CLK); #1;
    bus0.d_req = 1; bus0.d_we = 1; bus0.d_addr = 32'h40; bus0.d_wdata = 32'hDEAD_BEEF;
    @(posedge CLK); #1;
    reset_n = 0;
    bus0.d_req = 0; bus0.d_we = 0;
    @(negedge CLK);
    chk("midrst_i_ready", {31'b0, bus0.i_ready}, 32'd0);
    chk("midrst_d_ready", {31'b0, bus0.d_ready}, 32'd0);
    chk("midrst_i_rdata", bus0.i_rdata, 32'd0);
    chk("midrst_d_rdata", bus0.d_rdata, 32'd0);
    @(posedge CLK); #1;
    reset_n = 1;
    do_txn(1, 0, 32'h0000_0040, 32'h0, 0, lat, rd);
    chk("midrst_load_lat", lat, 32'd3);
    chk("midrst_load_rdata", rd, 32'hC0DE_0010);

    // LATENCY=1 instance: fetch held continuously.
    @(posedge CLK); #1;
    bus1.i_req = 1; bus1.i_addr = 32'h08;
    t0 = cyc;
    for (int k = 0; k < 13; k++) begin
      @(negedge CLK);
      if (bus1.i_ready) begin
        pulses.push_back(cyc - t0);
        chk("lat1_rdata", bus1.i_rdata, 32'hC0DE_0002);
      end
      @(posedge CLK); #1;
      if (cyc - t0 == 9) bus1.i_req = 0;
    end
    chk("lat1_pulse_count", pulses.size(), 32'd3);
    if (pulses.size() == 3) begin
      chk("lat1_pulse0", pulses[0], 32'd2);
      chk("lat1_pulse1", pulses[1], 32'd5);
      chk("lat1_pulse2", pulses[2], 32'd8);
    end

    repeat (3) @(posedge CLK);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
